// File: rtl/miriscv_lsu.sv
// miriscv load/store unit: core-side initiator of the data RAM port.
// Aligns requests, builds byte enables, stalls one cycle, extends loads.
module miriscv_lsu (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_misaligned_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i
);

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic {
    S_IDLE,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_off;
  logic [2:0]  r_size;
  logic        r_we;
  logic [31:0] r_data;

  logic        w_legal;
  logic        w_issue;
  logic        w_capture;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // Legality of the presented access: size code and natural alignment
  always_comb begin
    w_legal = 1'b0;
    unique case (lsu_size_i)
      SZ_B, SZ_BU: w_legal = 1'b1;
      SZ_H, SZ_HU: w_legal = ~lsu_addr_i[0];
      SZ_W:        w_legal = (lsu_addr_i[1:0] == 2'b00);
      default:     w_legal = 1'b0;
    endcase
    if (lsu_we_i && lsu_size_i[2]) begin
      w_legal = 1'b0;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_next           = r_state;
    data_req_o       = 1'b0;
    lsu_stall_req_o  = 1'b0;
    lsu_misaligned_o = 1'b0;
    w_issue          = 1'b0;
    w_capture        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (lsu_req_i) begin
          if (w_legal) begin
            data_req_o      = 1'b1;
            lsu_stall_req_o = 1'b1;
            w_issue         = 1'b1;
            w_next          = S_DONE;
          end else begin
            lsu_misaligned_o = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_capture = ~r_we;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign data_we_o   = lsu_we_i & data_req_o;
  assign data_addr_o = {lsu_addr_i[31:2], 2'b00};

  // Byte enables and lane-replicated store data
  always_comb begin
    data_be_o    = 4'b1111;
    data_wdata_o = lsu_data_i;
    if (lsu_we_i) begin
      unique case (lsu_size_i[1:0])
        2'b00: begin
          data_be_o    = 4'b0001 << lsu_addr_i[1:0];
          data_wdata_o = {4{lsu_data_i[7:0]}};
        end
        2'b01: begin
          data_be_o    = 4'b0011 << lsu_addr_i[1:0];
          data_wdata_o = {2{lsu_data_i[15:0]}};
        end
        default: begin
          data_be_o    = 4'b1111;
          data_wdata_o = lsu_data_i;
        end
      endcase
    end
  end

  assign w_byte = data_rdata_i[{r_off, 3'b000} +: 8];
  assign w_half = r_off[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];

  // Load data extraction from the registered offset and size
  always_comb begin
    w_ext = data_rdata_i;
    unique case (r_size)
      SZ_B:    w_ext = {{24{w_byte[7]}}, w_byte};
      SZ_BU:   w_ext = {24'b0, w_byte};
      SZ_H:    w_ext = {{16{w_half[15]}}, w_half};
      SZ_HU:   w_ext = {16'b0, w_half};
      default: w_ext = data_rdata_i;
    endcase
  end

  assign lsu_data_o = w_capture ? w_ext : r_data;

  // State, captured access attributes and load hold register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_off   <= 2'b00;
      r_size  <= 3'b000;
      r_we    <= 1'b0;
      r_data  <= 32'b0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_off  <= lsu_addr_i[1:0];
        r_size <= lsu_size_i;
        r_we   <= lsu_we_i;
      end
      if (w_capture) begin
        r_data <= w_ext;
      end
    end
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Bench for miriscv_lsu: word RAM responder plus byte-level
// reference memory, directed plan scenarios and random accesses.
module tb_miriscv_lsu;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o;
  logic        lsu_misaligned_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  ref_mem [0:1023];
  logic [31:0] ram     [0:255];
  logic [31:0] exp_hold;
  logic        pre_en;
  logic [31:0] w_tmp;

  miriscv_lsu dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n_i),
    .lsu_req_i        (lsu_req_i),
    .lsu_we_i         (lsu_we_i),
    .lsu_size_i       (lsu_size_i),
    .lsu_addr_i       (lsu_addr_i),
    .lsu_data_i       (lsu_data_i),
    .lsu_data_o       (lsu_data_o),
    .lsu_stall_req_o  (lsu_stall_req_o),
    .lsu_misaligned_o (lsu_misaligned_o),
    .data_req_o       (data_req_o),
    .data_we_o        (data_we_o),
    .data_be_o        (data_be_o),
    .data_addr_o      (data_addr_o),
    .data_wdata_o     (data_wdata_o),
    .data_rdata_i     (data_rdata_i)
  );

  always #5 clk = ~clk;

  // Synchronous RAM responder with one-cycle read latency
  always @(posedge clk) begin
    if (pre_en) begin
      for (int i = 0; i < 256; i++)
        ram[i] <= {ref_mem[4*i+3], ref_mem[4*i+2],
                   ref_mem[4*i+1], ref_mem[4*i]};
    end else if (data_req_o) begin
      if (data_we_o) begin
        w_tmp = ram[data_addr_o[9:2]];
        for (int k = 0; k < 4; k++)
          if (data_be_o[k]) w_tmp[8*k +: 8] = data_wdata_o[8*k +: 8];
        ram[data_addr_o[9:2]] <= w_tmp;
      end else begin
        data_rdata_i <= ram[data_addr_o[9:2]];
      end
    end
  end

  function automatic int nbytes(input logic [2:0] s);
    if (s[1:0] == 2'b00) return 1;
    if (s[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_legal(input logic we, input logic [2:0] s,
                                  input logic [31:0] a);
    if (s == 3'b011 || s[2:1] == 2'b11) return 1'b0;
    if (we && s[2]) return 1'b0;
    return (int'(a[9:0]) % nbytes(s)) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] s,
                                           input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(s);
    v = 32'h0;
    for (int i = 0; i < n; i++)
      v = v | (32'(ref_mem[int'(a[9:0]) + i]) << (8 * i));
    if (!s[2] && n < 4 && v[8*n-1])
      v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 in IDLE
  task automatic run_access(input logic we, input logic [2:0] s,
                            input logic [31:0] a, input logic [31:0] d);
    bit ok;
    int n;
    int off;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] exp;
    ok  = is_legal(we, s, a);
    n   = nbytes(s);
    off = int'(a[1:0]);
    lsu_req_i  = 1'b1;
    lsu_we_i   = we;
    lsu_size_i = s;
    lsu_addr_i = a;
    lsu_data_i = d;
    #1;
    n_checks++;
    if (lsu_misaligned_o !== logic'(!ok)) begin
      n_fail++;
      $display("FAIL misaligned a=%h s=%b: got %b want %b",
               a, s, lsu_misaligned_o, !ok);
    end
    n_checks++;
    if (data_req_o !== logic'(ok) || lsu_stall_req_o !== logic'(ok)) begin
      n_fail++;
      $display("FAIL idle_req_stall a=%h: got %b%b want %b%b",
               a, data_req_o, lsu_stall_req_o, ok, ok);
    end
    n_checks++;
    if (lsu_data_o !== exp_hold) begin
      n_fail++;
      $display("FAIL hold_idle: got %h want %h", lsu_data_o, exp_hold);
    end
    if (!ok) begin
      lsu_req_i = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (data_req_o !== 1'b0 || lsu_stall_req_o !== 1'b0) begin
        n_fail++;
        $display("FAIL after_misaligned: got %b%b want 00",
                 data_req_o, lsu_stall_req_o);
      end
      return;
    end
    n_checks++;
    if (data_we_o !== we || data_addr_o !== {a[31:2], 2'b00}) begin
      n_fail++;
      $display("FAIL we_addr: got %b %h want %b %h",
               data_we_o, data_addr_o, we, {a[31:2], 2'b00});
    end
    ebe = 4'b1111;
    ewd = data_wdata_o;
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        ebe[k] = (k >= off && k < off + n);
        ewd[8*k +: 8] = d[8*(k % n) +: 8];
      end
    end
    n_checks++;
    if (data_be_o !== ebe || data_wdata_o !== ewd) begin
      n_fail++;
      $display("FAIL be_wdata a=%h s=%b: got %b %h want %b %h",
               a, s, data_be_o, data_wdata_o, ebe, ewd);
    end
    @(posedge clk); #1;
    n_checks++;
    if (data_req_o !== 1'b0 || lsu_stall_req_o !== 1'b0 ||
        data_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL done_req_stall: got %b%b%b want 000",
               data_req_o, lsu_stall_req_o, data_we_o);
    end
    if (we) begin
      for (int i = 0; i < n; i++)
        ref_mem[int'(a[9:0]) + i] = d[8*i +: 8];
      exp = exp_hold;
    end else begin
      exp = ref_load(s, a);
      exp_hold = exp;
    end
    n_checks++;
    if (lsu_data_o !== exp) begin
      n_fail++;
      $display("FAIL done_data a=%h s=%b we=%b: got %h want %h",
               a, s, we, lsu_data_o, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n_i    = 1'b0;
    pre_en     = 1'b1;
    lsu_req_i  = 1'b0;
    lsu_we_i   = 1'b0;
    lsu_size_i = 3'b010;
    lsu_addr_i = 32'h0;
    lsu_data_i = 32'h0;
    exp_hold   = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (lsu_stall_req_o !== 1'b0 || data_req_o !== 1'b0 ||
        lsu_misaligned_o !== 1'b0 || lsu_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: got %b%b%b %h want 000 00000000",
               lsu_stall_req_o, data_req_o, lsu_misaligned_o, lsu_data_o);
    end
    pre_en  = 1'b0;
    rst_n_i = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    run_access(1'b0, 3'b000, 32'h100, 32'h0);
    n_checks++;
    if (lsu_data_o !== 32'hFFFF_FF80) begin
      n_fail++;
      $display("FAIL lb_hold: got %h want ffffff80", lsu_data_o);
    end
    run_access(1'b0, 3'b100, 32'h101, 32'h0);
    run_access(1'b0, 3'b001, 32'h102, 32'h0);
    run_access(1'b0, 3'b101, 32'h102, 32'h0);
    n_checks++;
    if (lsu_data_o !== 32'h0000_8001) begin
      n_fail++;
      $display("FAIL lhu_hold: got %h want 00008001", lsu_data_o);
    end
  endtask

  task automatic test_stores();
    run_access(1'b1, 3'b000, 32'h103, 32'h0000_00AB);
    run_access(1'b0, 3'b010, 32'h100, 32'h0);
    n_checks++;
    if (lsu_data_o !== 32'hAB01_7F80) begin
      n_fail++;
      $display("FAIL sb_then_lw: got %h want ab017f80", lsu_data_o);
    end
    run_access(1'b1, 3'b001, 32'h102, 32'h0000_1234);
    run_access(1'b1, 3'b010, 32'h102, 32'hDEAD_BEEF);
    run_access(1'b0, 3'b010, 32'h100, 32'h0);
    n_checks++;
    if (lsu_data_o !== 32'h1234_7F80) begin
      n_fail++;
      $display("FAIL sh_then_lw: got %h want 12347f80", lsu_data_o);
    end
  endtask

  task automatic test_illegal();
    run_access(1'b0, 3'b011, 32'h100, 32'h0);
    run_access(1'b0, 3'b110, 32'h104, 32'h0);
    run_access(1'b1, 3'b111, 32'h108, 32'h0);
    run_access(1'b1, 3'b100, 32'h10C, 32'h55);
    run_access(1'b0, 3'b001, 32'h101, 32'h0);
    run_access(1'b0, 3'b010, 32'h101, 32'h0);
  endtask

  task automatic test_reset_mid();
    lsu_req_i  = 1'b1;
    lsu_we_i   = 1'b0;
    lsu_size_i = 3'b010;
    lsu_addr_i = 32'h100;
    @(posedge clk); #1;
    rst_n_i   = 1'b0;
    lsu_req_i = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (lsu_stall_req_o !== 1'b0 || data_req_o !== 1'b0 ||
        lsu_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got %b%b %h want 00 00000000",
               lsu_stall_req_o, data_req_o, lsu_data_o);
    end
    rst_n_i  = 1'b1;
    exp_hold = 32'h0;
    @(posedge clk); #1;
    run_access(1'b0, 3'b010, 32'h100, 32'h0);
  endtask

  task automatic test_idle();
    lsu_req_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      lsu_we_i   = 1'($urandom);
      lsu_addr_i = 32'($urandom_range(0, 1023));
      @(posedge clk); #1;
      n_checks++;
      if (data_req_o !== 1'b0 || lsu_stall_req_o !== 1'b0 ||
          data_we_o !== 1'b0 || lsu_data_o !== exp_hold) begin
        n_fail++;
        $display("FAIL idle %0d: got %b%b%b %h want 000 %h", i,
                 data_req_o, lsu_stall_req_o, data_we_o, lsu_data_o, exp_hold);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  s;
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      s = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0)
        a = a & ~32'(nbytes(s) - 1);
      run_access(1'($urandom), s, a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        lsu_req_i = 1'b0;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
    ref_mem[256] = 8'h80;
    ref_mem[257] = 8'h7F;
    ref_mem[258] = 8'h01;
    ref_mem[259] = 8'h80;
    test_reset();
    test_loads();
    test_stores();
    test_illegal();
    test_reset_mid();
    test_idle();
    test_random();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
